// File: rtl/fft_cache_mm_sl_mc_if.sv
// -----------------------------------------------------------------------------
// fft_cache_mm_sl_mc_if
// Avalon-MM bus bundle between the interconnect (master) and the FFT result
// cache slave.
//   av_read_ih / av_write_ih     : read / write request from the master
//   av_addr_id                   : byte address
//   av_write_data_id             : write data
//   av_waitrequest_oh            : slave stalls the current request
//   av_read_data_od              : read data
//   av_read_data_valid_oh        : av_read_data_od is valid this cycle
// -----------------------------------------------------------------------------
interface fft_cache_mm_sl_mc_if #(
    parameter int P_LB_ADDR_W = 12,
    parameter int P_LB_DATA_W = 32
);
    logic                   av_read_ih;
    logic                   av_write_ih;
    logic [P_LB_ADDR_W-1:0] av_addr_id;
    logic [P_LB_DATA_W-1:0] av_write_data_id;
    logic                   av_waitrequest_oh;
    logic [P_LB_DATA_W-1:0] av_read_data_od;
    logic                   av_read_data_valid_oh;

    modport master (
        output av_read_ih, av_write_ih, av_addr_id, av_write_data_id,
        input  av_waitrequest_oh, av_read_data_od, av_read_data_valid_oh
    );

    modport slave (
        input  av_read_ih, av_write_ih, av_addr_id, av_write_data_id,
        output av_waitrequest_oh, av_read_data_od, av_read_data_valid_oh
    );
endinterface

// File: rtl/fft_cache_mm_sl_mc.sv
// -----------------------------------------------------------------------------
// fft_cache_mm_sl_mc
// Avalon-MM slave giving the host pipelined, in-order read access to a bank of
// FFT result RAMs that share one read address. A small register space drives a
// freeze handshake with the FFT engine so RAM reads only happen while the
// spectra are stable (RAM reads stall until the engine has acknowledged).
//
// Ports:
//   av_clk_ir               : clock
//   av_rst_il               : asynchronous active-low reset
//   av                      : Avalon-MM slave bundle (see fft_cache_mm_sl_mc_if)
//   fft_res_ram_rd_addr_od  : shared RAM word address, combinational from av
//   fft_res_ram_data_id     : RAM read data, channel k at [k*W +: W]
//   fft_freeze_req_oh       : ask the engine to stop updating the RAMs
//   fft_freeze_ack_ih       : engine confirms the RAMs are frozen
//
// Register map (address MSB = 1, word index = addr[3:2]):
//   0 CTRL   : bit0 freeze_en (RW)
//   1 STATUS : bit0 frozen (RO), bit1 wr_err (sticky, write 1 to clear)
//   2 RD_CNT : accepted RAM reads, saturating; any write clears it
//   3        : reads 0, writes ignored
// -----------------------------------------------------------------------------
module fft_cache_mm_sl_mc #(
    parameter int P_LB_ADDR_W      = 12,
    parameter int P_LB_DATA_W      = 32,
    parameter int P_FFT_RAM_ADDR_W = 7,
    parameter int P_FFT_RAM_DATA_W = 32,
    parameter int P_CHNL_SEL_W     = 2,
    parameter int P_RD_DELAY       = 2,
    parameter int P_RD_CNT_W       = 16
) (
    input  logic                                              av_clk_ir,
    input  logic                                              av_rst_il,
    fft_cache_mm_sl_mc_if.slave                               av,
    output logic [P_FFT_RAM_ADDR_W-1:0]                       fft_res_ram_rd_addr_od,
    input  logic [(2**P_CHNL_SEL_W)*P_FFT_RAM_DATA_W-1:0]     fft_res_ram_data_id,
    output logic                                              fft_freeze_req_oh,
    input  logic                                              fft_freeze_ack_ih
);

    localparam int P_NUM_CHNLS = 2**P_CHNL_SEL_W;
    localparam int LAST        = P_RD_DELAY - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FROZEN = 2'd2,
        REL    = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic                      freeze_en;
    logic                      wr_err;
    logic [P_RD_CNT_W-1:0]     rd_cnt;

    logic                      addr_msb;
    logic [1:0]                reg_idx;
    logic [P_CHNL_SEL_W-1:0]   chnl;
    logic                      accept;
    logic                      ram_accept;
    logic                      reg_wr;
    logic                      bad_wr;
    logic [P_LB_DATA_W-1:0]    reg_rdata;
    logic [P_LB_DATA_W-1:0]    ram_word;

    // Read pipeline: one slot per RAM latency cycle.
    logic                      pipe_valid  [P_RD_DELAY];
    logic                      pipe_is_reg [P_RD_DELAY];
    logic [P_CHNL_SEL_W-1:0]   pipe_chnl   [P_RD_DELAY];
    logic [P_LB_DATA_W-1:0]    pipe_rdata  [P_RD_DELAY];

    // ------------------------------------------------------------------------
    // Address decode and handshake
    // ------------------------------------------------------------------------
    assign addr_msb               = av.av_addr_id[P_LB_ADDR_W-1];
    assign reg_idx                = av.av_addr_id[3:2];
    assign chnl                   = av.av_addr_id[2+P_FFT_RAM_ADDR_W +: P_CHNL_SEL_W];
    assign fft_res_ram_rd_addr_od = av.av_addr_id[2 +: P_FFT_RAM_ADDR_W];

    // Only RAM reads stall, and only until the engine has really frozen.
    assign av.av_waitrequest_oh = av.av_read_ih & ~addr_msb & (state != FROZEN);

    assign accept     = av.av_read_ih & ~av.av_waitrequest_oh;
    assign ram_accept = accept & ~addr_msb;

    // A write that coincides with a read is dropped; so is any RAM-space write.
    assign reg_wr = av.av_write_ih & ~av.av_read_ih & addr_msb;
    assign bad_wr = av.av_write_ih & (av.av_read_ih | ~addr_msb);

    assign fft_freeze_req_oh = (state == REQ) || (state == FROZEN);

    // NOTE: every always_comb assigns a default to each output first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        reg_rdata = '0;
        case (reg_idx)
            2'd0:    reg_rdata[0] = freeze_en;
            2'd1:    reg_rdata[1:0] = {wr_err, state == FROZEN};
            2'd2:    reg_rdata[P_RD_CNT_W-1:0] = rd_cnt;
            default: reg_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Freeze FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge av_clk_ir or negedge av_rst_il) begin
        if (!av_rst_il) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (freeze_en)          state_nxt = REQ;
            REQ:     if (!freeze_en)         state_nxt = REL;
                     else if (fft_freeze_ack_ih) state_nxt = FROZEN;
            FROZEN:  if (!freeze_en)         state_nxt = REL;
            REL:     if (!fft_freeze_ack_ih) state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge av_clk_ir or negedge av_rst_il) begin
        if (!av_rst_il) begin
            freeze_en <= 1'b0;
            wr_err    <= 1'b0;
            rd_cnt    <= '0;
        end else begin
            if (reg_wr && reg_idx == 2'd0)
                freeze_en <= av.av_write_data_id[0];

            if (bad_wr)
                wr_err <= 1'b1;
            else if (reg_wr && reg_idx == 2'd1 && av.av_write_data_id[1])
                wr_err <= 1'b0;

            // Clear has priority over the increment.
            if (reg_wr && reg_idx == 2'd2)
                rd_cnt <= '0;
            else if (ram_accept && rd_cnt != '1)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline and output register
    // ------------------------------------------------------------------------
    // NOTE: the pipeline payload is reset along with the valid bits because a
    // reset must discard in-flight reads completely; these are a few flops,
    // not a RAM, so the reset costs nothing structurally.
    always_ff @(posedge av_clk_ir or negedge av_rst_il) begin
        if (!av_rst_il) begin
            for (int i = 0; i < P_RD_DELAY; i++) begin
                pipe_valid[i]  <= 1'b0;
                pipe_is_reg[i] <= 1'b0;
                pipe_chnl[i]   <= '0;
                pipe_rdata[i]  <= '0;
            end
        end else begin
            pipe_valid[0]  <= accept;
            pipe_is_reg[0] <= addr_msb;
            pipe_chnl[0]   <= chnl;
            pipe_rdata[0]  <= reg_rdata;
            for (int i = 1; i < P_RD_DELAY; i++) begin
                pipe_valid[i]  <= pipe_valid[i-1];
                pipe_is_reg[i] <= pipe_is_reg[i-1];
                pipe_chnl[i]   <= pipe_chnl[i-1];
                pipe_rdata[i]  <= pipe_rdata[i-1];
            end
        end
    end

    // RAM data for the oldest read is on the bus while it sits in the last slot.
    always_comb begin
        ram_word = '0;
        ram_word[P_FFT_RAM_DATA_W-1:0] =
            fft_res_ram_data_id[int'(pipe_chnl[LAST])*P_FFT_RAM_DATA_W +: P_FFT_RAM_DATA_W];
    end

    always_ff @(posedge av_clk_ir or negedge av_rst_il) begin
        if (!av_rst_il) begin
            av.av_read_data_valid_oh <= 1'b0;
            av.av_read_data_od       <= '0;
        end else begin
            av.av_read_data_valid_oh <= pipe_valid[LAST];
            if (pipe_valid[LAST])
                av.av_read_data_od <= pipe_is_reg[LAST] ? pipe_rdata[LAST] : ram_word;
        end
    end

endmodule

// File: tb/tb_fft_cache_mm_sl_mc.sv
// -----------------------------------------------------------------------------
// tb_fft_cache_mm_sl_mc
// Directed bench for fft_cache_mm_sl_mc with default parameters. Expected read
// responses and their arrival cycle are queued when a read is accepted and are
// compared by a monitor when av_read_data_valid_oh fires.
// -----------------------------------------------------------------------------
module tb_fft_cache_mm_sl_mc;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RAW = 7;
    localparam int RDW = 32;
    localparam int CSW = 2;
    localparam int NCH = 4;
    localparam int RDLY = 2;

    localparam logic [AW-1:0] A_CTRL   = 12'h800;
    localparam logic [AW-1:0] A_STATUS = 12'h804;
    localparam logic [AW-1:0] A_RDCNT  = 12'h808;
    localparam logic [AW-1:0] A_RSVD   = 12'h80C;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        string         tag;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [RAW-1:0] ram_addr;
    logic [NCH*RDW-1:0] ram_data;
    logic freeze_req;
    logic freeze_ack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    fft_cache_mm_sl_mc_if #(.P_LB_ADDR_W(AW), .P_LB_DATA_W(DW)) bus ();

    fft_cache_mm_sl_mc #(
        .P_LB_ADDR_W(AW), .P_LB_DATA_W(DW), .P_FFT_RAM_ADDR_W(RAW),
        .P_FFT_RAM_DATA_W(RDW), .P_CHNL_SEL_W(CSW), .P_RD_DELAY(RDLY),
        .P_RD_CNT_W(16)
    ) dut (
        .av_clk_ir              (clk),
        .av_rst_il              (rst_n),
        .av                     (bus.slave),
        .fft_res_ram_rd_addr_od (ram_addr),
        .fft_res_ram_data_id    (ram_data),
        .fft_freeze_req_oh      (freeze_req),
        .fft_freeze_ack_ih      (freeze_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM bank model: RDLY-cycle read latency, word = 0xC0000000|(ch<<8)|addr.
    logic [RAW-1:0] ram_pipe [RDLY];
    always @(posedge clk) begin
        ram_pipe[0] <= ram_addr;
        for (int i = 1; i < RDLY; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    always @* begin
        for (int k = 0; k < NCH; k++)
            ram_data[k*RDW +: RDW] = 32'hC000_0000 | (32'(k) << 8) | 32'(ram_pipe[RDLY-1]);
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ram_val(input int ch, input int word);
        return 32'hC000_0000 | (32'(ch) << 8) | 32'(word);
    endfunction

    function automatic logic [AW-1:0] ram_addr_of(input int ch, input int word);
        return AW'((ch << (2 + RAW)) | (word << 2));
    endfunction

    // Response monitor: every valid must match the oldest queued expectation,
    // both in data and in the cycle it was due.
    always @(negedge clk) begin
        if (bus.av_read_data_valid_oh) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'b0, bus.av_read_data_valid_oh}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_data"}, bus.av_read_data_od, e.data);
                check({e.tag, "_latency"}, DW'(cyc), DW'(e.due));
            end
        end
    end

    // Present a read (optionally with a simultaneous write) and hold it until
    // accepted; leaves the request asserted so reads can follow back-to-back.
    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] e,
                              input string tag, input bit with_wr = 1'b0);
        int n;
        exp_t item;
        n = 0;
        bus.av_read_ih       = 1'b1;
        bus.av_write_ih      = with_wr;
        bus.av_addr_id       = a;
        bus.av_write_data_id = '0;
        #1;
        while (bus.av_waitrequest_oh && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.av_waitrequest_oh) begin
            check({tag, "_stall_timeout"}, {31'b0, bus.av_waitrequest_oh}, '0);
        end else begin
            item.data = e;
            item.due  = cyc + RDLY + 1;
            item.tag  = tag;
            sb.push_back(item);
        end
        @(negedge clk);
        bus.av_write_ih = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.av_read_ih       = 1'b0;
        bus.av_write_ih      = 1'b1;
        bus.av_addr_id       = a;
        bus.av_write_data_id = d;
        @(negedge clk);
        bus.av_write_ih = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.av_read_ih  = 1'b0;
        bus.av_write_ih = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.av_read_ih  = 1'b0;
        bus.av_write_ih = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_pending"}, DW'(sb.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                = 1'b0;
        freeze_ack           = 1'b0;
        bus.av_read_ih       = 1'b0;
        bus.av_write_ih      = 1'b0;
        bus.av_addr_id       = '0;
        bus.av_write_data_id = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdata", bus.av_read_data_od, '0);
        check("rst_valid", {31'b0, bus.av_read_data_valid_oh}, '0);
        check("rst_req",   {31'b0, freeze_req}, '0);
        check("rst_wait",  {31'b0, bus.av_waitrequest_oh}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register reads after reset never stall and return 0
        issue_read(A_CTRL,   32'h0, "rd_ctrl0");
        issue_read(A_STATUS, 32'h0, "rd_status0");
        issue_read(A_RDCNT,  32'h0, "rd_rdcnt0");
        issue_read(A_RSVD,   32'h0, "rd_rsvd0");
        drain("init");

        // Freeze request: freeze_en lands one edge after the write, REQ one later
        do_write(A_CTRL, 32'h1);
        @(negedge clk);
        check("req_after_ctrl", {31'b0, freeze_req}, 32'h1);
        issue_read(A_STATUS, 32'h0, "status_in_req");
        idle(1);

        // RAM read stalls while the engine has not acknowledged
        bus.av_read_ih = 1'b1;
        bus.av_addr_id = 12'h010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wait", {31'b0, bus.av_waitrequest_oh}, 32'h1);
            @(negedge clk);
        end
        freeze_ack = 1'b1;
        issue_read(12'h010, ram_val(0, 4), "stalled_ram_rd");
        issue_read(A_STATUS, 32'h1, "status_frozen");
        drain("freeze");

        // Back-to-back reads across all channels, then mixed register/RAM order
        for (int ch = 0; ch < NCH; ch++)
            issue_read(ram_addr_of(ch, 5), ram_val(ch, 5), $sformatf("b2b_ch%0d", ch));
        issue_read(A_RDCNT, 32'd5, "rdcnt_mid");
        issue_read(ram_addr_of(2, 127), ram_val(2, 127), "ram_top_word");
        issue_read(A_RDCNT, 32'd6, "rdcnt_after");
        drain("b2b");

        // Error handling
        do_write(12'h020, 32'hDEAD_BEEF);
        issue_read(A_STATUS, 32'h3, "status_wr_err");
        idle(1);
        do_write(A_STATUS, 32'h2);
        issue_read(A_STATUS, 32'h1, "status_cleared");
        issue_read(A_RDCNT,  32'd6, "rd_with_wr", 1'b1);
        issue_read(A_STATUS, 32'h3, "status_rw_err");
        issue_read(A_RDCNT,  32'd6, "rdcnt_not_cleared");
        issue_read(A_CTRL,   32'h1, "ctrl_rb");
        idle(1);
        do_write(A_STATUS, 32'h2);
        do_write(A_RDCNT, 32'h1234);
        do_write(A_RSVD, 32'hFFFF_FFFF);
        issue_read(A_RDCNT, 32'h0, "rdcnt_cleared");
        issue_read(A_RSVD,  32'h0, "rsvd_ignored");
        drain("err");

        // Unfreeze with a RAM read still in flight; it must complete
        issue_read(ram_addr_of(1, 3), ram_val(1, 3), "inflight_at_release");
        do_write(A_CTRL, 32'h0);
        @(negedge clk);
        check("req_released", {31'b0, freeze_req}, '0);
        bus.av_read_ih = 1'b1;
        bus.av_addr_id = 12'h010;
        #1;
        check("stall_in_rel", {31'b0, bus.av_waitrequest_oh}, 32'h1);
        idle(1);
        freeze_ack = 1'b0;
        idle(2);
        issue_read(A_STATUS, 32'h0, "status_idle");
        drain("release");

        // Reset with two RAM reads in flight
        freeze_ack = 1'b1;
        do_write(A_CTRL, 32'h1);
        idle(3);
        check("req_refrozen", {31'b0, freeze_req}, 32'h1);
        issue_read(ram_addr_of(3, 9), ram_val(3, 9), "lost0");
        issue_read(ram_addr_of(0, 9), ram_val(0, 9), "lost1");
        bus.av_read_ih = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_rdata", bus.av_read_data_od, '0);
        check("mid_rst_valid", {31'b0, bus.av_read_data_valid_oh}, '0);
        check("mid_rst_req",   {31'b0, freeze_req}, '0);
        freeze_ack = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(8);
        check("post_rst_valid", {31'b0, bus.av_read_data_valid_oh}, '0);
        check("post_rst_req",   {31'b0, freeze_req}, '0);
        issue_read(A_CTRL, 32'h0, "ctrl_after_rst");
        drain("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
